// File: rtl/pow2_mul_seq.sv
// Sequential multiply-by-2^k engine: shifts one bit per cycle and saturates to all-ones on overflow.
// Valid/ready on both sides. At most one operation is in flight at a time.
module pow2_mul_seq #(
    parameter int unsigned IN_WIDTH  = 3,
    parameter int unsigned SH_WIDTH  = 2,
    parameter int unsigned OUT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic [SH_WIDTH-1:0]  shift,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 sat
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state, state_nxt;
    logic [OUT_WIDTH-1:0] acc;
    logic [SH_WIDTH-1:0]  cnt;
    logic                 sat_r;
    logic                 accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (shift != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                if (cnt == SH_WIDTH'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Every bit leaving the word passes through the MSB first, so checking
    // the MSB before each shift catches every overflow. There is no early exit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc   <= '0;
            cnt   <= '0;
            sat_r <= 1'b0;
        end else if (accept) begin
            acc   <= OUT_WIDTH'(din);
            cnt   <= shift;
            sat_r <= 1'b0;
        end else if (state == SHIFT) begin
            if (acc[OUT_WIDTH-1]) sat_r <= 1'b1;
            acc <= acc << 1;
            cnt <= cnt - SH_WIDTH'(1);
        end
    end

    assign dout = sat_r ? '1 : acc;
    assign sat  = sat_r;

endmodule

// File: tb/tb_pow2_mul_seq.sv
// Directed and randomized checks for pow2_mul_seq (IN=3, SH=2, OUT=4).
module tb_pow2_mul_seq;

    logic       clk;
    logic       resetn;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] din;
    logic [1:0] shift;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] dout;
    logic       sat;

    int n_chk  = 0;
    int n_fail = 0;

    pow2_mul_seq #(.IN_WIDTH(3), .SH_WIDTH(2), .OUT_WIDTH(4)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .sat(sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] din;
        logic [1:0] sh;
        logic [3:0] dout;
        logic       sat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operand, measure latency, optionally stall, then handshake.
    task automatic do_op(input logic [2:0] d, input logic [1:0] k,
                         input logic [3:0] exp_dout, input logic exp_sat,
                         input int stall, input string name);
        int n;
        check({name, " in_ready before accept"}, int'(in_ready), 1);
        in_valid = 1'b1;
        din      = d;
        shift    = k;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                in_valid = 1'b0;
                din      = 3'($urandom_range(0, 7));
                shift    = 2'($urandom_range(0, 3));
            end
        end while (!out_valid && n < 20);
        check({name, " latency"}, n, 1 + int'(k));
        check({name, " dout"}, int'(dout), int'(exp_dout));
        check({name, " sat"}, int'(sat), int'(exp_sat));
        check({name, " in_ready in DONE"}, int'(in_ready), 0);
        for (int i = 0; i < stall; i++) begin
            tick();
            check({name, " stall dout"}, int'(dout), int'(exp_dout));
            check({name, " stall out_valid"}, int'(out_valid), 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " out_valid after handshake"}, int'(out_valid), 0);
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        shift     = '0;

        vecs[0] = '{3'd3, 2'd0, 4'd3,  1'b0};
        vecs[1] = '{3'd3, 2'd2, 4'd12, 1'b0};
        vecs[2] = '{3'd1, 2'd3, 4'd8,  1'b0};
        vecs[3] = '{3'd5, 2'd1, 4'd10, 1'b0};
        vecs[4] = '{3'd5, 2'd2, 4'd15, 1'b1};
        vecs[5] = '{3'd7, 2'd3, 4'd15, 1'b1};
        vecs[6] = '{3'd0, 2'd3, 4'd0,  1'b0};
        vecs[7] = '{3'd7, 2'd1, 4'd14, 1'b0};
        vecs[8] = '{3'd4, 2'd2, 4'd15, 1'b1};
        vecs[9] = '{3'd1, 2'd0, 4'd1,  1'b0};

        // Operand offered during reset must not be captured.
        repeat (2) tick();
        in_valid = 1'b1;
        din      = 3'd5;
        shift    = 2'd0;
        tick();
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_valid", int'(out_valid), 0);
        in_valid = 1'b0;
        resetn   = 1'b1;
        tick();
        check("post-reset in_ready", int'(in_ready), 1);
        check("post-reset out_valid", int'(out_valid), 0);
        check("post-reset dout", int'(dout), 0);
        check("post-reset sat", int'(sat), 0);

        foreach (vecs[i])
            do_op(vecs[i].din, vecs[i].sh, vecs[i].dout, vecs[i].sat, 0,
                  $sformatf("vec%0d", i));

        // Backpressure: the producer keeps offering din=6 while the result stalls.
        in_valid = 1'b1;
        din      = 3'd3;
        shift    = 2'd1;
        tick();
        din   = 3'd6;
        shift = 2'd0;
        tick();
        check("bp out_valid", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp dout stable", int'(dout), 6);
            check("bp in_ready", int'(in_ready), 0);
            check("bp out_valid held", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp idle out_valid", int'(out_valid), 0);
        check("bp idle in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("bp second out_valid", int'(out_valid), 1);
        check("bp second dout", int'(dout), 6);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Assert reset asynchronously in the middle of the second shift cycle.
        in_valid = 1'b1;
        din      = 3'd2;
        shift    = 2'd3;
        tick();
        in_valid = 1'b0;
        tick();
        #2 resetn = 1'b0;
        #1;
        check("midrst out_valid", int'(out_valid), 0);
        check("midrst in_ready", int'(in_ready), 1);
        check("midrst dout", int'(dout), 0);
        #2 resetn = 1'b1;
        tick();
        check("midrst idle out_valid", int'(out_valid), 0);
        do_op(3'd1, 2'd1, 4'd2, 1'b0, 0, "after reset");

        // Back-to-back random stream with random consumer stalls.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] d;
            logic [1:0] k;
            int p;
            d = 3'($urandom_range(0, 7));
            k = 2'($urandom_range(0, 3));
            p = int'(d) << k;
            do_op(d, k, (p > 15) ? 4'd15 : 4'(p), p > 15,
                  int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
